// File: rtl/beep_sequencer.sv
// Prioritised multi-source alert-tone generator: turns rising edges on event_in
// into fixed-length square-wave beeps written to the codec at its accept rate.
module beep_sequencer #(
  parameter int                    NUM_SRC    = 2,
  parameter int                    SAMPLE_W   = 32,
  parameter logic [SAMPLE_W-1:0]   AMPLITUDE  = 32'h0800_0000,
  parameter int                    HP_W       = 16,
  parameter int                    DUR_W      = 24,
  parameter int                    GAP_CYCLES = 1_000_000,
  localparam int                   SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       event_in,
  input  logic [NUM_SRC*HP_W-1:0]  half_period,
  input  logic [DUR_W-1:0]         beep_cycles,
  input  logic                     audio_out_allowed,
  output logic                     write_audio_out,
  output logic [SAMPLE_W-1:0]      sample_out,
  output logic                     beep_active,
  output logic [SRC_W-1:0]         beep_src
);

  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BEEP,
    GAP
  } state_t;

  state_t               state, state_n;
  logic [NUM_SRC-1:0]   event_d;
  logic [NUM_SRC-1:0]   pend, pend_n;
  logic [NUM_SRC-1:0]   rise, req;
  logic [NUM_SRC-1:0]   cur_mask, lower_mask;
  logic                 start, retrig;
  logic [SRC_W-1:0]     start_src;
  logic [DUR_W-1:0]     dur_cnt, dur_load;
  logic [GAP_W-1:0]     gap_cnt;
  logic [HP_W-1:0]      hp_lat, hp_sel;
  logic [HP_W-1:0]      sample_cnt;
  logic                 phase;

  function automatic logic [SRC_W-1:0] lowest(input logic [NUM_SRC-1:0] v);
    lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = SRC_W'(i);
    end
  endfunction

  // Masks of the sounding source and of every source that outranks it.
  always_comb begin
    rise       = event_in & ~event_d;
    req        = pend | rise;
    cur_mask   = '0;
    lower_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cur_mask[i]   = (beep_src == SRC_W'(i));
      lower_mask[i] = (SRC_W'(i) < beep_src);
    end
  end

  // NOTE: every variable gets a default before the case so no path can leave
  // one unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    start_src = beep_src;
    retrig    = 1'b0;
    pend_n    = pend | rise;
    unique case (state)
      IDLE: begin
        if (|req) begin
          start     = 1'b1;
          start_src = lowest(req);
        end
      end
      BEEP: begin
        // A rise on the sounding source never queues it again.
        pend_n = pend | (rise & ~cur_mask);
        if (|(rise & lower_mask)) begin
          start     = 1'b1;
          start_src = lowest(req);
        end else if (|(rise & cur_mask)) begin
          retrig = 1'b1;
        end else if (dur_cnt <= DUR_W'(1)) begin
          if (|pend_n) begin
            if (GAP_CYCLES > 0) begin
              state_n = GAP;
            end else begin
              start     = 1'b1;
              start_src = lowest(pend_n);
            end
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          start     = 1'b1;
          start_src = lowest(req);
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n = BEEP;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (start_src == SRC_W'(i)) pend_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    hp_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (start_src == SRC_W'(i)) hp_sel = half_period[i*HP_W +: HP_W];
    end
    if (hp_sel == '0) hp_sel = HP_W'(1);
    dur_load = (beep_cycles == '0) ? DUR_W'(1) : beep_cycles;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    // Loading event_d during reset keeps levels held through reset from triggering.
    event_d <= event_in;
    if (reset) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      beep_src   <= '0;
      hp_lat     <= '0;
      dur_cnt    <= '0;
      gap_cnt    <= '0;
      sample_cnt <= '0;
      phase      <= 1'b1;
    end else begin
      if (state_n == GAP && state != GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      if (start) begin
        beep_src   <= start_src;
        hp_lat     <= hp_sel;
        dur_cnt    <= dur_load;
        phase      <= 1'b1;
        sample_cnt <= '0;
      end else begin
        if (retrig) begin
          dur_cnt <= dur_load;
        end else if (state == BEEP && dur_cnt != '0) begin
          dur_cnt <= dur_cnt - DUR_W'(1);
        end
        // Tone advances only on accepted writes, so its period is in samples.
        if (state == BEEP && write_audio_out) begin
          if (sample_cnt == hp_lat - HP_W'(1)) begin
            sample_cnt <= '0;
            phase      <= ~phase;
          end else begin
            sample_cnt <= sample_cnt + HP_W'(1);
          end
        end
      end
    end
  end

  assign write_audio_out = audio_out_allowed & ~reset;
  assign beep_active     = (state == BEEP);
  assign sample_out      = beep_active ? (phase ? AMPLITUDE : -AMPLITUDE) : '0;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer: single beep, preemption, queueing, retrigger,
// throttled codec and reset corners, with hand-derived lengths and tone patterns.
module tb_beep_sequencer;

  localparam logic [31:0] AMP     = 32'h0800_0000;
  localparam logic [31:0] NEG_AMP = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  event_in;
  logic [31:0] half_period;
  logic [23:0] beep_cycles;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] sample_out;
  logic        beep_active;
  logic [0:0]  beep_src;

  int checks   = 0;
  int failures = 0;

  beep_sequencer #(
    .NUM_SRC    (2),
    .SAMPLE_W   (32),
    .AMPLITUDE  (AMP),
    .HP_W       (16),
    .DUR_W      (24),
    .GAP_CYCLES (10)
  ) dut (
    .CLOCK_50          (clk),
    .reset             (reset),
    .event_in          (event_in),
    .half_period       (half_period),
    .beep_cycles       (beep_cycles),
    .audio_out_allowed (audio_out_allowed),
    .write_audio_out   (write_audio_out),
    .sample_out        (sample_out),
    .beep_active       (beep_active),
    .beep_src          (beep_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [1:0] v);
    event_in = v;
    tick();
    event_in = 2'b00;
  endtask

  // Counts beep cycles from the current one; models the tone from accepted writes.
  task automatic run_beep(input int hp, input int retrig_at, input bit throttle,
                          output int n, output int bad, output int wbad);
    int          w;
    logic [31:0] exp_s;
    n = 0; bad = 0; wbad = 0; w = 0;
    while (beep_active && n < 1000) begin
      if (hp > 0) begin
        exp_s = (((w / hp) % 2) == 0) ? AMP : NEG_AMP;
        if (sample_out !== exp_s) bad++;
      end
      n++;
      if (retrig_at != 0) event_in[0] = (n == retrig_at);
      audio_out_allowed = throttle ? ((n % 8) == 1) : 1'b1;
      #1;
      if (write_audio_out !== audio_out_allowed) wbad++;
      if (audio_out_allowed) w++;
      tick();
    end
    audio_out_allowed = 1'b1;
  endtask

  task automatic run_idle(input int bound, output int n);
    n = 0;
    while (!beep_active && n < bound) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, wbad, act;

    reset             = 1'b1;
    event_in          = 2'b00;
    half_period       = {16'd3, 16'd4};
    beep_cycles       = 24'd100;
    audio_out_allowed = 1'b1;
    repeat (3) tick();
    check("rst_active", beep_active, 1'b0);
    check("rst_sample", sample_out, 32'h0);
    check("rst_write", write_audio_out, 1'b0);
    check("rst_src", beep_src, 1'b0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_write", write_audio_out, 1'b1);

    // Single beep: 100 cycles, +AMPx4 / -AMPx4 starting high.
    trigger(2'b01);
    check("single_start", beep_active, 1'b1);
    check("single_src", beep_src, 1'b0);
    run_beep(4, 0, 1'b0, n, bad, wbad);
    check("single_len", n, 100);
    check("single_tone_bad", bad, 0);
    check("single_after_sample", sample_out, 32'h0);
    repeat (5) tick();

    // Preemption: src 1 at t, src 0 at t+20; src 1 is dropped.
    event_in = 2'b10;
    tick();
    check("pre_src1_start", beep_src, 1'b1);
    repeat (19) tick();
    event_in = 2'b11;
    tick();
    check("pre_active", beep_active, 1'b1);
    check("pre_src0", beep_src, 1'b0);
    run_beep(4, 0, 1'b0, n, bad, wbad);
    check("pre_len", n, 100);
    check("pre_tone_bad", bad, 0);
    run_idle(40, n);
    check("pre_no_replay", n, 40);
    event_in = 2'b00;
    repeat (3) tick();

    // Dropped source rises again during a beep: gap, then its own beep.
    trigger(2'b01);
    repeat (10) tick();
    event_in = 2'b10;
    tick();
    event_in = 2'b00;
    run_beep(0, 0, 1'b0, n, bad, wbad);
    check("queue_len", n + 11, 100);
    run_idle(200, n);
    check("queue_gap", n, 10);
    check("queue_src1", beep_src, 1'b1);
    run_beep(3, 0, 1'b0, n, bad, wbad);
    check("queue_src1_len", n, 100);
    check("queue_src1_tone_bad", bad, 0);
    repeat (5) tick();

    // Simultaneous rises: src 0, gap, src 1.
    trigger(2'b11);
    check("sim_src0", beep_src, 1'b0);
    run_beep(4, 0, 1'b0, n, bad, wbad);
    check("sim_len0", n, 100);
    run_idle(200, n);
    check("sim_gap", n, 10);
    check("sim_src1", beep_src, 1'b1);
    run_beep(3, 0, 1'b0, n, bad, wbad);
    check("sim_len1", n, 100);
    run_idle(30, n);
    check("sim_then_idle", n, 30);

    // Retrigger at cycle 60: 160 cycles total, tone continuous.
    trigger(2'b01);
    run_beep(4, 60, 1'b0, n, bad, wbad);
    check("retrig_len", n, 160);
    check("retrig_tone_bad", bad, 0);
    event_in = 2'b00;
    repeat (5) tick();

    // Throttled codec: one accept in eight, half-period 2.
    half_period = {16'd3, 16'd2};
    trigger(2'b01);
    run_beep(2, 0, 1'b1, n, bad, wbad);
    check("thr_len", n, 100);
    check("thr_tone_bad", bad, 0);
    check("thr_write_mirror_bad", wbad, 0);
    half_period = {16'd3, 16'd4};
    repeat (5) tick();

    // Zero duration is treated as one cycle.
    beep_cycles = 24'd0;
    trigger(2'b01);
    run_beep(4, 0, 1'b0, n, bad, wbad);
    check("dur0_len", n, 1);
    beep_cycles = 24'd100;
    repeat (5) tick();

    // Input held high through reset release never triggers.
    event_in = 2'b01;
    reset    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    act   = 0;
    repeat (20) begin
      tick();
      if (beep_active) act++;
    end
    check("held_no_beep", act, 0);
    event_in = 2'b00;
    repeat (3) tick();

    // Reset mid-beep with src 1 pending: silence next cycle, pending lost.
    trigger(2'b01);
    repeat (5) tick();
    trigger(2'b10);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midrst_active", beep_active, 1'b0);
    check("midrst_sample", sample_out, 32'h0);
    check("midrst_write", write_audio_out, 1'b0);
    reset = 1'b0;
    act   = 0;
    repeat (150) begin
      tick();
      if (beep_active) act++;
    end
    check("midrst_pend_lost", act, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

Multi-source, parametrised alert-tone generator that feeds the audio codec path. It converts N obstacle/event inputs into prioritised, fixed-length square-wave beeps. Each source has its own per-source tone pitch and a shared duration. Samples are produced at the codec's consumption rate and presented on the Audio_Controller's left/right sample inputs. `beep_active` is provided to gate codec setup and reset logic.

## Interface
Parameters:
- `NUM_SRC`, 2: number of event sources; index 0 has the highest priority.
- `SAMPLE_W`, 32: audio sample width, two's complement.
- `AMPLITUDE`, 32'h0800_0000: positive peak of the square wave; must be < 2^(SAMPLE_W-1).
- `HP_W`, 16: width of each half-period field, counted in codec samples.
- `DUR_W`, 24: width of the duration counter, counted in clock cycles.
- `GAP_CYCLES`, 1_000_000: silent cycles between back-to-back beeps; 0 allowed.

Ports:
- `CLOCK_50` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `event_in` in NUM_SRC: per-source request levels; a beep is triggered on each rising edge.
- `half_period` in NUM_SRC*HP_W: per-source tone half-period in samples; source i occupies bits [i*HP_W +: HP_W].
- `beep_cycles` in DUR_W: beep length in CLOCK_50 cycles.
- `audio_out_allowed` in 1: codec FIFO can accept a sample this cycle.
- `write_audio_out` out 1: sample write strobe to the codec.
- `sample_out` out SAMPLE_W: current sample, driven to both channels.
- `beep_active` out 1: high while in the BEEP state.
- `beep_src` out clog2(NUM_SRC), minimum 1 bit: index of the source currently sounding, or of the last source that sounded.

## Operation
- Edge detect: `rise = event_in & ~event_d`, where `event_d` is a register. During reset, `event_d` loads `event_in`, so inputs held high through reset never trigger.
- Pending mask `pend[NUM_SRC]`: set by `rise`; cleared for a source when that source is started.
- Arbitration: the selected source is the lowest-indexed set bit of `pend | rise`.
- State machine:
  - IDLE: if any `pend | rise`, go to BEEP with the selected source.
  - BEEP: the duration counter counts down. At terminal count:
    - if `pend` is nonzero and GAP_CYCLES > 0, go to GAP;
    - if `pend` is nonzero and GAP_CYCLES = 0, go directly to BEEP with the next source;
    - otherwise go to IDLE.
  - GAP: count GAP_CYCLES cycles, then go to BEEP with the selected source. Events that arrive during GAP take part in that selection.
- In BEEP, a rise on the current source is a retrigger: the duration counter reloads, the tone phase is not reset, and no pending bit is set.
- In BEEP, a rise on a source with a lower index than `beep_src` is a preemption: the new beep starts on the next edge with no gap. The interrupted source is dropped, not re-queued.
- In BEEP, a rise on a source with a higher index only sets its pending bit.
- Beep start (any entry into BEEP, including preemption):
  - latch the source's `half_period` (0 is treated as 1);
  - load the duration with `beep_cycles` (0 is treated as 1);
  - set phase = high and clear the sample counter.
- Tone: only cycles with `write_audio_out` = 1 in BEEP advance the sample counter. When the counter reaches the latched half-period, the phase toggles and the counter clears.
- `sample_out`: +AMPLITUDE when phase is high and state is BEEP, −AMPLITUDE when phase is low and state is BEEP, 0 otherwise. It is a combinational decode of registered state.
- `write_audio_out = audio_out_allowed & ~reset`. Silence (zeros) is written in IDLE and GAP, so the codec FIFO never underruns.

## Timing
- Reset values: state IDLE, `pend` 0, all counters 0, phase high, `beep_active` 0, `beep_src` 0, `sample_out` 0. `write_audio_out` is 0 while reset is high.
- Reset mid-beep: the next cycle is IDLE with silence; the pending bits are lost.
- Trigger latency: a rise visible at edge k gives `beep_active` = 1 from edge k+1.
- Beep length: `beep_active` is high for exactly `beep_cycles` consecutive cycles, unless retriggered or preempted.
- Gap length: exactly GAP_CYCLES cycles with `beep_active` = 0 between queued beeps.
- Simultaneous rises: the lowest index is served first and the others stay pending. A rise that coincides with terminal count is treated as pending, never lost.
- Sample counting: the tone period is exactly 2×half_period accepted writes, independent of how `audio_out_allowed` is spaced.

## Test plan
- Single beep (NUM_SRC=2, beep_cycles=100, half_period[0]=4, `audio_out_allowed` always 1):
  - stimulus: pulse `event_in[0]` once;
  - response: `beep_active` is high for exactly 100 cycles, `beep_src`=0, and `sample_out` alternates +AMP×4 / −AMP×4 starting high, then returns to 0.
- Queued beeps (GAP_CYCLES=10):
  - stimulus: raise `event_in[1]`, then `event_in[0]` 20 cycles later;
  - response: at +21, src 0 preempts; then 100 cycles of src 0. The dropped src 1 does not replay unless it rises again during the beep, in which case a 10-cycle gap follows and then a src-1 beep.
- Simultaneous rises:
  - stimulus: `event_in`=2'b11 in the same cycle;
  - response: src 0 beeps for 100 cycles, then a 10-cycle gap, then src 1 beeps for 100 cycles.
- Retrigger:
  - stimulus: re-pulse `event_in[0]` at cycle 60 of a beep;
  - response: total beep of 160 cycles, no gap, tone phase continuous.
- Throttled codec:
  - stimulus: `audio_out_allowed` high 1 cycle in 8, half_period=2;
  - response: the phase toggles every 2 writes (16 clocks), and `write_audio_out` mirrors `audio_out_allowed`.
- Reset corners:
  - stimulus: `event_in[0]` held high through reset release;
  - response: no beep.
  - stimulus: reset asserted mid-beep;
  - response: `beep_active` and `sample_out` are 0 next cycle and pending beeps are lost.
